// File: rtl/ov7670_cfg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_cfg_arbiter_if
// Description : Bundle between the camera configuration arbiter, the camera
//               request sources and the shared SCCB configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ov7670_cfg_arbiter_if;
  logic [2:0] req;        // per-camera request: bit0 left, bit1 center, bit2 right
  logic       cfg_done;   // done flag from the shared SCCB controller
  logic       cfg_start;  // one-cycle resend pulse to the shared controller
  logic [2:0] sel;        // one-hot camera grant (000 = no camera driven)
  logic [2:0] cfg_ok;     // sticky per-camera success flags
  logic [2:0] cfg_err;    // sticky per-camera timeout flags
  logic       busy;       // arbiter not idle

  // Arbiter side
  modport master (
    input  req,
    input  cfg_done,
    output cfg_start,
    output sel,
    output cfg_ok,
    output cfg_err,
    output busy
  );

  // Requesters / controller side
  modport slave (
    output req,
    output cfg_done,
    input  cfg_start,
    input  sel,
    input  cfg_ok,
    input  cfg_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/ov7670_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_cfg_arbiter
// Description : Round-robin arbiter that shares one SCCB configuration
//               controller between three OV7670 cameras. Grants one camera
//               at a time, pulses a resend, waits for a fresh done (or a
//               timeout) and holds the grant for a settle guard period.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_cfg_arbiter #(
  parameter int C_TIMEOUT  = 1000000,
  parameter int C_SETTLE   = 16,
  parameter bit C_INIT_ALL = 1'b1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  ov7670_cfg_arbiter_if.master bus
);

  localparam int C_TMO_W = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam int C_SET_W = (C_SETTLE > 1) ? $clog2(C_SETTLE) : 1;
  localparam logic [C_TMO_W-1:0] C_TMO_MAX  = C_TMO_W'(C_TIMEOUT);
  localparam logic [C_SET_W-1:0] C_SET_LAST = C_SET_W'(C_SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_START     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_SETTLE    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_pending;
  logic [1:0]           r_last;
  logic [1:0]           w_pick;
  logic [2:0]           w_pick_oh;
  logic                 w_grant;
  logic [C_TMO_W-1:0]   r_tmo_cnt;
  logic [C_SET_W-1:0]   r_set_cnt;
  logic                 w_tmo_hit;
  logic                 w_set_last;
  logic                 w_done_ok;
  logic                 w_tmo_err;
  logic [2:0]           r_sel;
  logic                 r_cfg_start;
  logic [2:0]           r_cfg_ok;
  logic [2:0]           r_cfg_err;
  logic                 r_busy;

  assign w_grant    = (r_state == S_ARB);
  assign w_tmo_hit  = (r_tmo_cnt == C_TMO_MAX);
  assign w_set_last = (r_set_cnt == C_SET_LAST);
  assign w_pick_oh  = 3'b001 << w_pick;

  // Round-robin pick: search starts one past the last granted camera.
  always_comb begin
    w_pick = 2'd0;
    case (r_last)
      2'd0:    w_pick = r_pending[1] ? 2'd1 : (r_pending[2] ? 2'd2 : 2'd0);
      2'd1:    w_pick = r_pending[2] ? 2'd2 : (r_pending[0] ? 2'd0 : 2'd1);
      default: w_pick = r_pending[0] ? 2'd0 : (r_pending[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Next-state decode; a fresh done wins over a simultaneous timeout.
  always_comb begin
    w_next    = r_state;
    w_done_ok = 1'b0;
    w_tmo_err = 1'b0;
    case (r_state)
      S_IDLE:      if (r_pending != 3'b000) w_next = S_ARB;
      S_ARB:       w_next = S_START;
      S_START:     w_next = S_WAIT_LOW;
      S_WAIT_LOW: begin
        // A done still high from the previous camera is ignored here.
        if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
          w_next    = S_SETTLE;
        end else if (!bus.cfg_done) begin
          w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.cfg_done) begin
          w_done_ok = 1'b1;
          w_next    = S_SETTLE;
        end else if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
          w_next    = S_SETTLE;
        end
      end
      S_SETTLE:    if (w_set_last) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Pending requests and round-robin history; a grant clears its bit, a new
  // request in the same cycle re-arms it so no request is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= C_INIT_ALL ? 3'b111 : 3'b000;
      r_last    <= 2'd2;
    end else begin
      r_pending <= (r_pending & ~(w_grant ? w_pick_oh : 3'b000)) | bus.req;
      if (w_grant) r_last <= w_pick;
    end
  end

  // Timeout counter (saturating) and settle guard counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_set_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT_LOW || r_state == S_WAIT_DONE) && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (r_state == S_SETTLE) r_set_cnt <= r_set_cnt + 1'b1;
      else                     r_set_cnt <= '0;
    end
  end

  // Registered outputs; sel only changes on entering START or leaving SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 3'b000;
      r_cfg_start <= 1'b0;
      r_cfg_ok    <= 3'b000;
      r_cfg_err   <= 3'b000;
      r_busy      <= 1'b0;
    end else begin
      r_cfg_start <= w_grant;
      r_busy      <= (w_next != S_IDLE);
      if (w_grant) begin
        r_sel     <= w_pick_oh;
        r_cfg_ok  <= r_cfg_ok & ~w_pick_oh;
        r_cfg_err <= r_cfg_err & ~w_pick_oh;
      end
      if (w_done_ok) r_cfg_ok  <= r_cfg_ok | r_sel;
      if (w_tmo_err) r_cfg_err <= r_cfg_err | r_sel;
      if (r_state == S_SETTLE && w_set_last) r_sel <= 3'b000;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.cfg_start = r_cfg_start;
  assign bus.cfg_ok    = r_cfg_ok;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_cfg_arbiter
// Description : Self-checking bench for ov7670_cfg_arbiter. A driver plays
//               the requesters and the SCCB controller; a model of the
//               round-robin rules predicts each grant and its outcome; a
//               monitor checks every grant against the predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_cfg_arbiter;

  localparam int T = 120;  // timeout
  localparam int S = 4;    // settle cycles

  typedef struct {
    int cam;   // expected winner 0..2
    bit ok;    // expected outcome
    int x;     // decision cycle, counted from the cfg_start cycle
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ov7670_cfg_arbiter_if bus();

  ov7670_cfg_arbiter #(
    .C_TIMEOUT (T),
    .C_SETTLE  (S),
    .C_INIT_ALL(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   n_start  = 0;
  exp_t sb[$];
  bit [2:0] m_pend;
  int   m_last;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Next camera under round-robin: first pending one after the last grant.
  function automatic int pick();
    for (int i = 1; i <= 3; i++)
      if (m_pend[(m_last + i) % 3]) return (m_last + i) % 3;
    return -1;
  endfunction

  // One configuration: predict, then act as controller.
  // stuck: done never drops. r: cycle done rises. inj/ic: req pulse at cycle ic.
  task automatic serve_one(input bit stuck, input int r, input bit [2:0] inj, input int ic);
    int w; bit ok; int x; int n;
    w = pick();
    m_pend[w] = 1'b0;
    m_last = w;
    ok = !stuck && (r >= 3) && (r <= T + 1);
    x  = ok ? r : T + 1;
    sb.push_back('{w, ok, x});
    n = 0;
    while (!bus.cfg_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_start_seen", int'(bus.cfg_start), 1);
    if (!bus.cfg_start) return;
    for (int c = 1; c <= x + 1; c++) begin
      @(negedge clk);
      bus.req = (c == ic) ? inj : 3'b000;
      if (c == ic) m_pend |= inj;
      if (!stuck && c == 2) bus.cfg_done = 1'b0;
      if (!stuck && c == r) bus.cfg_done = 1'b1;
    end
    @(negedge clk);
    bus.req = 3'b000;
    bus.cfg_done = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("busy_low_when_done", int'(bus.busy), 0);
    chk("sel_zero_when_idle", int'(bus.sel), 0);
  endtask

  task automatic pulse_req(input bit [2:0] v);
    @(negedge clk);
    bus.req = v;
    m_pend |= v;
    @(negedge clk);
    bus.req = 3'b000;
  endtask

  // Monitor: pops a prediction at each cfg_start and checks the grant.
  initial begin : monitor
    exp_t cur;
    bit   act;
    int   dur;
    act = 1'b0;
    dur = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
        continue;
      end
      chk("sel_onehot_or_zero", int'($countones(bus.sel) <= 1), 1);
      if (bus.cfg_start) begin
        n_start++;
        chk("prediction_available", sb.size(), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          act = 1'b1;
          dur = 0;
          chk("grant_sel", int'(bus.sel), 1 << cur.cam);
          chk("ok_cleared_at_start", int'(bus.cfg_ok[cur.cam]), 0);
          chk("err_cleared_at_start", int'(bus.cfg_err[cur.cam]), 0);
        end
      end
      if (act) begin
        if (bus.sel != 3'b000) begin
          dur++;
        end else begin
          chk("sel_hold_cycles", dur, cur.x + 1 + S);
          chk("cfg_ok_result", int'(bus.cfg_ok[cur.cam]), int'(cur.ok));
          chk("cfg_err_result", int'(bus.cfg_err[cur.cam]), int'(!cur.ok));
          act = 1'b0;
        end
      end
    end
  end

  // Stimulus
  initial begin : driver
    int n0;
    bit [2:0] v;
    bus.req = 3'b000;
    bus.cfg_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_sel", int'(bus.sel), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_cfg_start", int'(bus.cfg_start), 0);
    chk("reset_cfg_ok", int'(bus.cfg_ok), 0);
    chk("reset_cfg_err", int'(bus.cfg_err), 0);
    m_pend = 3'b111;
    m_last = 2;
    #2 rst_n = 1'b1;

    // Power-up: all three configured in order left, center, right.
    n0 = n_start;
    repeat (3) serve_one(1'b0, 102, 3'b000, 0);
    wait_idle();
    chk("powerup_cfg_ok", int'(bus.cfg_ok), 7);
    chk("powerup_cfg_err", int'(bus.cfg_err), 0);
    chk("powerup_start_pulses", n_start - n0, 3);

    // Center and right requested together: center first, then right.
    pulse_req(3'b110);
    repeat (2) serve_one(1'b0, 10, 3'b000, 0);
    wait_idle();

    // Left times out with done stuck high; center still gets served.
    pulse_req(3'b011);
    serve_one(1'b1, 0, 3'b000, 0);
    serve_one(1'b0, 15, 3'b000, 0);
    wait_idle();
    chk("stuck_err_left", int'(bus.cfg_err[0]), 1);
    chk("stuck_ok_left", int'(bus.cfg_ok[0]), 0);
    chk("after_stuck_ok_center", int'(bus.cfg_ok[1]), 1);

    // Done arriving exactly at the timeout boundary, then one cycle late.
    pulse_req(3'b001);
    serve_one(1'b0, T + 1, 3'b000, 0);
    wait_idle();
    chk("boundary_ok", int'(bus.cfg_ok[0]), 1);
    pulse_req(3'b001);
    serve_one(1'b0, T + 2, 3'b000, 0);
    wait_idle();
    chk("late_err", int'(bus.cfg_err[0]), 1);

    // Center re-requested while being configured, left pending.
    pulse_req(3'b011);
    serve_one(1'b0, 20, 3'b010, 5);
    serve_one(1'b0, 8, 3'b000, 0);
    serve_one(1'b0, 9, 3'b000, 0);
    wait_idle();

    // Randomized rounds.
    for (int k = 0; k < 25; k++) begin
      v = 3'($urandom_range(1, 7));
      pulse_req(v);
      while (m_pend != 3'b000) begin
        bit stuck; int r; bit [2:0] inj; int ic;
        stuck = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
          0:       r = 3 + $urandom_range(0, 10);
          1:       r = $urandom_range(3, T + 1);
          2:       r = T + 1;
          default: r = T + 2;
        endcase
        inj = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
        ic  = $urandom_range(1, 4);
        serve_one(stuck, r, inj, ic);
      end
      wait_idle();
    end

    // Reset during WAIT_DONE aborts; sequence restarts from left.
    pulse_req(3'b100);
    sb.push_back('{2, 1'b1, 50});
    m_pend = 3'b000;
    m_last = 2;
    n0 = 0;
    while (!bus.cfg_start && n0 < 50) begin
      @(negedge clk);
      n0++;
    end
    chk("abort_txn_started", int'(bus.cfg_start), 1);
    repeat (2) @(negedge clk);
    bus.cfg_done = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sel", int'(bus.sel), 0);
    chk("async_reset_busy", int'(bus.busy), 0);
    chk("async_reset_cfg_start", int'(bus.cfg_start), 0);
    chk("async_reset_cfg_ok", int'(bus.cfg_ok), 0);
    chk("async_reset_cfg_err", int'(bus.cfg_err), 0);
    sb.delete();
    m_pend = 3'b111;
    m_last = 2;
    bus.cfg_done = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) serve_one(1'b0, 30, 3'b000, 0);
    wait_idle();
    chk("post_reset_cfg_ok", int'(bus.cfg_ok), 7);

    repeat (5) @(negedge clk);
    chk("predictions_consumed", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ov7670_cfg_arbiter.md
OV7670_CFG_ARBITER -- requirements
Module: ov7670_cfg_arbiter

Interface
REQ-001 SHALL have parameter C_TIMEOUT, default 1000000: max clk cycles per configuration attempt.
REQ-002 SHALL have parameter C_SETTLE, default 16: guard cycles between consecutive camera configurations.
REQ-003 SHALL have parameter C_INIT_ALL, default 1: when 1, all three cameras are pending at reset release.
REQ-004 SHALL have port clk  in  1  system clock (50 MHz domain); the single clock of the block.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  in  3  per-camera configuration request, level-sampled; bit0 left, bit1 center, bit2 right.
REQ-007 SHALL have port cfg_done  in  1  done flag from the shared SCCB configuration controller.
REQ-008 SHALL have port cfg_start  out  1  one-cycle resend pulse to the shared controller.
REQ-009 SHALL have port sel  out  3  one-hot camera grant; gates that camera's siod/sioc drivers; 000 = no camera driven.
REQ-010 SHALL have port cfg_ok  out  3  sticky per-camera "configured successfully" flags.
REQ-011 SHALL have port cfg_err  out  3  sticky per-camera timeout flags.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL hold a 3-bit pending register: pending |= req every cycle; the granted bit clears in the cycle that START is entered.
REQ-014 SHALL implement states IDLE, ARB, START, WAIT_LOW, WAIT_DONE, SETTLE.
REQ-015 IDLE -> ARB when pending != 000; otherwise stay in IDLE with sel = 000.
REQ-016 ARB SHALL pick round-robin: search order starts at (last granted + 1) mod 3; after reset, last granted = right, so left wins first; ARB -> START in 1 cycle.
REQ-017 START SHALL assert sel to the winner and pulse cfg_start for exactly one cycle, clear that camera's cfg_ok and cfg_err bits, load the timeout counter to 0, then go to WAIT_LOW.
REQ-018 WAIT_LOW: when cfg_done = 0, go to WAIT_DONE; this prevents a stale done from the previous camera being accepted.
REQ-019 WAIT_DONE: when cfg_done = 1, set cfg_ok[winner] and go to SETTLE.
REQ-020 The timeout counter SHALL increment each cycle in WAIT_LOW and WAIT_DONE and be ceil(log2(C_TIMEOUT+1)) bits wide, with no wrap.
REQ-021 When the counter reaches C_TIMEOUT in WAIT_LOW or WAIT_DONE, the block SHALL set cfg_err[winner] and go to SETTLE; done has priority if it arrives in the same cycle.
REQ-022 SETTLE: sel SHALL stay asserted for C_SETTLE cycles, then sel = 000 and the state goes to IDLE; an error does not retry automatically.
REQ-023 req for the camera currently being configured SHALL re-set its pending bit; that camera is then served again after the others, in round-robin order.
REQ-024 sel SHALL be one-hot or zero at all times and SHALL change only on entering START or leaving SETTLE.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On rst_n = 0, the block SHALL asynchronously reset to: state IDLE, sel 000, cfg_start 0, busy 0, cfg_ok 000, cfg_err 000, counters 0, last granted = right.
REQ-027 On reset, pending SHALL load 111 if C_INIT_ALL = 1, else 000.
REQ-028 Reset asserted mid-configuration SHALL abort the configuration immediately; sel drops to 000 within the reset assertion with no cfg_start glitch.

Verification
REQ-029 Power-up, C_INIT_ALL = 1, controller model drops done 2 cycles after start and raises it 100 cycles later -> cameras configured in order l, c, r; cfg_ok = 111; cfg_err = 000; exactly 3 cfg_start pulses; busy falls after the third SETTLE.
REQ-030 C_INIT_ALL = 0, req = 110 for one cycle, last granted = right -> center first, then right; sel sequence 010, 100; left never selected.
REQ-031 cfg_done stuck high, C_TIMEOUT = 50 -> cfg_err[0] set 50 cycles after WAIT_LOW entry; cfg_ok[0] = 0; arbitration continues to the next pending camera.
REQ-032 cfg_done rises in the same cycle the counter reaches C_TIMEOUT -> cfg_ok set, cfg_err clear.
REQ-033 req[1] pulsed while center is in WAIT_DONE, with left pending -> left served next, then center reconfigured; cfg_ok[1] cleared at its second START.
REQ-034 rst_n pulsed low during WAIT_DONE -> sel = 000 and busy = 0 asynchronously; after release, the sequence restarts from left.
